// File: rtl/mem_pkg.sv
// Shared definitions for the clearable simple dual-port RAM family.
package mem_pkg;

    // Clear engine states: CLEAR sweeps the array, IDLE is normal operation.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } mem_state_e;

    // The only supported read latencies.
    localparam int OD_ONE = 32'sd1;
    localparam int OD_TWO = 32'sd2;

    // Address width for a given depth; never narrower than one bit.
    function automatic int addr_width(input int depth);
        int w;
        if (depth <= 32'sd2) begin
            w = 32'sd1;
        end else begin
            w = $clog2(depth);
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_sdp_clr_fwd_if.sv
// Write/read/clear bus of the clearable simple dual-port RAM.
interface mem_sdp_clr_fwd_if #(
    parameter int DATA_WIDTH = 8,
    parameter int AW         = 6
);
    logic                  clr;
    logic                  busy;
    logic                  wea;
    logic [AW-1:0]         addra;
    logic [DATA_WIDTH-1:0] dia;
    logic                  reb;
    logic [AW-1:0]         addrb;
    logic [DATA_WIDTH-1:0] dob;
    logic                  dob_valid;

    modport master (
        output clr, wea, addra, dia, reb, addrb,
        input  busy, dob, dob_valid
    );

    modport slave (
        input  clr, wea, addra, dia, reb, addrb,
        output busy, dob, dob_valid
    );
endinterface

// File: rtl/mem_clr_sequencer.sv
// Clear engine: sweeps every address to DEFAULT_VALUE after reset or clr,
// and owns the RAM write port while it does so.
module mem_clr_sequencer
    import mem_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    DEPTH         = 36,
    parameter int                    AW            = 6,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  wea,
    input  logic [AW-1:0]         addra,
    input  logic [DATA_WIDTH-1:0] dia,
    output logic                  busy,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 32'sd1);
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

    mem_state_e      state_r;
    mem_state_e      state_nx_s;
    logic [AW-1:0]   clr_addr_r;
    logic [AW-1:0]   clr_addr_nx_s;
    logic            busy_r;

    // Next state and next clear address; clr always restarts at address 0.
    always_comb begin
        state_nx_s    = state_r;
        clr_addr_nx_s = clr_addr_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr) begin
                    clr_addr_nx_s = {AW{1'b0}};
                end else if (clr_addr_r == LAST_ADDR) begin
                    state_nx_s    = ST_IDLE;
                    clr_addr_nx_s = {AW{1'b0}};
                end else begin
                    clr_addr_nx_s = clr_addr_r + AW'(1);
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_nx_s    = ST_CLEAR;
                    clr_addr_nx_s = {AW{1'b0}};
                end else begin
                    clr_addr_nx_s = clr_addr_r;
                end
            end
            default: begin
                state_nx_s    = ST_CLEAR;
                clr_addr_nx_s = {AW{1'b0}};
            end
        endcase
    end

    // State, sweep address and busy flag; reset lands in a fresh sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_CLEAR;
            clr_addr_r <= {AW{1'b0}};
            busy_r     <= 1'b1;
        end else begin
            state_r    <= state_nx_s;
            clr_addr_r <= clr_addr_nx_s;
            busy_r     <= (state_nx_s == ST_CLEAR);
        end
    end

    // Write-port mux: the sweep wins; user writes pass only in IDLE and in range.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = addra;
        mem_din  = dia;
        if (state_r == ST_CLEAR) begin
            mem_we   = 1'b1;
            mem_addr = clr_addr_r;
            mem_din  = DEFAULT_VALUE;
        end else if (wea && ({1'b0, addra} < DEPTH_W)) begin
            mem_we   = 1'b1;
        end else begin
            mem_we   = 1'b0;
        end
    end

    assign busy = busy_r;

endmodule

// File: rtl/mem_sdp_clr_fwd.sv
// Simple dual-port RAM with synchronous read, hardware clear sweep,
// optional same-address write forwarding and a 1- or 2-stage read pipeline.
module mem_sdp_clr_fwd
    import mem_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    DEPTH         = 36,
    parameter int                    OUTPUT_DELAY  = 1,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = {DATA_WIDTH{1'b0}},
    parameter int                    FORWARD       = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_sdp_clr_fwd_if.slave  bus
);

    localparam int          AW      = addr_width(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    localparam bit          FWD_EN  = (FORWARD != 32'sd0);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic                  busy_s;
    logic                  mem_we_s;
    logic [AW-1:0]         mem_addr_s;
    logic [DATA_WIDTH-1:0] mem_din_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic [DATA_WIDTH-1:0] rd1_r;
    logic                  rd1_v_r;

    mem_clr_sequencer #(
        .DATA_WIDTH    (DATA_WIDTH),
        .DEPTH         (DEPTH),
        .AW            (AW),
        .DEFAULT_VALUE (DEFAULT_VALUE)
    ) u_seq (
        .clk      (clk),
        .reset    (reset),
        .clr      (bus.clr),
        .wea      (bus.wea),
        .addra    (bus.addra),
        .dia      (bus.dia),
        .busy     (busy_s),
        .mem_we   (mem_we_s),
        .mem_addr (mem_addr_s),
        .mem_din  (mem_din_s)
    );

    // Storage array; deliberately not reset, the clear sweep initialises it.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_addr_s] <= mem_din_s;
        end
    end

    // Read data: default while sweeping or out of range, else forward or array.
    always_comb begin
        rd_data_s = DEFAULT_VALUE;
        if (busy_s) begin
            rd_data_s = DEFAULT_VALUE;
        end else if ({1'b0, bus.addrb} >= DEPTH_W) begin
            rd_data_s = DEFAULT_VALUE;
        end else if (FWD_EN && bus.wea && (bus.addra == bus.addrb)) begin
            rd_data_s = bus.dia;
        end else begin
            rd_data_s = mem_r[bus.addrb];
        end
    end

    // Stage 1: data captured only on a read, valid tracks reb every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd1_r   <= DEFAULT_VALUE;
            rd1_v_r <= 1'b0;
        end else begin
            rd1_v_r <= bus.reb;
            if (bus.reb) begin
                rd1_r <= rd_data_s;
            end
        end
    end

    if (OUTPUT_DELAY == OD_ONE) begin : g_od1
        assign bus.dob       = rd1_r;
        assign bus.dob_valid = rd1_v_r;
    end else if (OUTPUT_DELAY == OD_TWO) begin : g_od2
        logic [DATA_WIDTH-1:0] rd2_r;
        logic                  rd2_v_r;

        // Stage 2: unconditional copy of stage 1 for the longer latency.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rd2_r   <= DEFAULT_VALUE;
                rd2_v_r <= 1'b0;
            end else begin
                rd2_r   <= rd1_r;
                rd2_v_r <= rd1_v_r;
            end
        end

        assign bus.dob       = rd2_r;
        assign bus.dob_valid = rd2_v_r;
    end else begin : g_bad_delay
        $fatal(1, "mem_sdp_clr_fwd: OUTPUT_DELAY must be 1 or 2");
        assign bus.dob       = DEFAULT_VALUE;
        assign bus.dob_valid = 1'b0;
    end

    assign bus.busy = busy_s;

endmodule

// File: doc/mem_sdp_clr_fwd.md
Name: mem_sdp_clr_fwd

Overview:
- Parametrised successor to the team's simple dual-port RAM: one clock, synchronous BRAM-style read, and a hardware clear engine.
- The clear engine sweeps every address to DEFAULT_VALUE after reset and on request.
- Optional write-to-read forwarding for same-address collisions.
- Read-valid pipeline of 1 or 2 stages.
- Used by operator/channel state memories that must start from a known value without relying on FPGA init contents.

Parameters:
- DATA_WIDTH, 8, width of stored word.
- DEPTH, 36, number of words; need not be a power of two; AW = $clog2(DEPTH), minimum 1.
- OUTPUT_DELAY, 1, read latency in cycles; legal values 1 or 2; any other value is a fatal elaboration error.
- DEFAULT_VALUE, 0, value loaded by the clear engine and driven on dob during reset and busy.
- FORWARD, 1, 1 = a same-cycle same-address read returns the new write data; 0 = it returns the old contents.

Ports:
- clk  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-high reset.
- clr  input  1  single-cycle pulse; starts or restarts a full clear sweep.
- busy  output  1  high while the clear sweep runs.
- wea  input  1  write enable.
- addra  input  AW  write address.
- dia  input  DATA_WIDTH  write data.
- reb  input  1  read enable.
- addrb  input  AW  read address.
- dob  output  DATA_WIDTH  read data.
- dob_valid  output  1  dob holds the result of a reb request.

Behaviour:
- Reset (asynchronous, while asserted):
  - state = CLEAR, clear address = 0, busy = 1.
  - All output pipeline registers = DEFAULT_VALUE; valid bits = 0.
  - RAM array contents are not reset by reset.
- State machine, two states:
  - CLEAR: write DEFAULT_VALUE to clear address each cycle, then increment. After writing address DEPTH-1, go to IDLE on the next edge.
  - IDLE: normal operation. A clr pulse in IDLE goes to CLEAR with address 0.
  - A clr pulse during CLEAR restarts the sweep at address 0.
  - A sweep takes exactly DEPTH cycles. busy falls on the edge after the DEPTH-1 write.
  - Reset mid-sweep restarts the sweep from 0 after reset deasserts.
- Writes during busy:
  - User writes (wea) are dropped, never queued.
  - The clear engine owns the write port.
- Reads during busy:
  - reb is still honoured and dob_valid pulses with normal latency.
  - Data returned is DEFAULT_VALUE regardless of array contents.
- Read pipeline:
  - Stage 1 register is updated only when reb=1; it holds otherwise.
  - valid1 = reb, registered.
  - Stage 2 always copies stage 1 and valid1.
  - OUTPUT_DELAY=1: dob/dob_valid come from stage 1; data appears the cycle after reb.
  - OUTPUT_DELAY=2: dob/dob_valid come from stage 2; data appears two cycles after reb.
  - dob holds its last value when no read occurs; dob_valid is a one-cycle pulse per request.
- Collision (IDLE, wea=1, reb=1, addra==addrb):
  - FORWARD=1: the read returns dia.
  - FORWARD=0: the read returns the pre-write contents.
  - The array always ends with dia.
- Out-of-range addresses (>= DEPTH, possible when DEPTH is not a power of two):
  - Writes are ignored.
  - Reads return DEFAULT_VALUE with valid asserted.
- Back-to-back reads at full rate are supported: one result per cycle.

Decomposition:
- Shared package mem_pkg:
  - state enum (CLEAR, IDLE).
  - Helper function for AW (clog2 with minimum 1).
  - Legal OUTPUT_DELAY constants.
- One natural sub-module: mem_clr_sequencer.
  - Contains the state register, clear address counter, busy flag and the write-port mux (clear write vs user write).
  - The RAM array, forwarding compare and output pipeline stay in the top module.

Test Plan:
- Reset release, DEPTH=36, DEFAULT_VALUE=8'h5A → busy=1 for exactly 36 cycles. Afterwards, a read of every address 0..35 returns 8'h5A with dob_valid one cycle after reb (OUTPUT_DELAY=1).
- IDLE: write addr 3 = 8'hC3, then reb addr 3 next cycle → dob=8'hC3, dob_valid=1 exactly one cycle later. With OUTPUT_DELAY=2 the same stimulus gives data two cycles after reb.
- Collision at addr 7 (old 8'h11, write 8'h22) → FORWARD=1 returns 8'h22; FORWARD=0 returns 8'h11. A subsequent read returns 8'h22 in both cases.
- clr pulse mid-sweep at cycle 20, and wea=1 to addr 0 with 8'hFF during busy → sweep restarts at address 0, busy lasts 36 cycles from the clr, and addr 0 reads 8'h5A afterwards (write dropped).
- Reset asserted asynchronously (not on a clock edge) mid-sweep and mid-read → dob=DEFAULT_VALUE and dob_valid=0 immediately. The sweep restarts from 0 and takes 36 cycles after deassertion.
- Full-rate reads, addresses 0..35 back-to-back after writing addr=data → 36 consecutive dob_valid pulses, data matching addresses in order. Reads of addr 36..63 return DEFAULT_VALUE.
